// File: rtl/mmio_port_unit.sv
// Memory-mapped I/O window in the MEM stage: output port, synchronised input port,
// sticky input-change flag with interrupt copy, and a loadable free-running cycle counter.
module mmio_port_unit #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        IOSelect,
    output logic [31:0] PortOut,
    output logic        ChangeIRQ
);

    typedef enum logic [1:0] {
        OFF_PORT_OUT = 2'd0,
        OFF_PORT_IN  = 2'd1,
        OFF_STATUS   = 2'd2,
        OFF_CYCLE    = 2'd3
    } reg_off_t;

    reg_off_t    off;
    logic        we;
    logic [31:0] port_out_q;
    logic [7:0]  in_s1;
    logic [7:0]  in_s2;
    logic [7:0]  in_prev;
    logic        changed;
    logic        change_irq;
    logic [31:0] cycle_q;
    logic [31:0] rd_value;
    logic        change_seen;
    logic        status_clear;
    logic        unused_addr_bits;

    // Stores are word-only; the byte lane bits carry no meaning here.
    assign unused_addr_bits = ^Address[1:0];

    assign IOSelect     = (Address[31:4] == BASE_ADDR[31:4]);
    assign off          = reg_off_t'(Address[3:2]);
    assign we           = MemWrite & IOSelect;
    assign change_seen  = (in_s2 != in_prev);
    assign status_clear = we && (off == OFF_STATUS) && WriteData[0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= OUT_RESET;
            in_s1      <= 8'h00;
            in_s2      <= 8'h00;
            in_prev    <= 8'h00;
            changed    <= 1'b0;
            change_irq <= 1'b0;
            cycle_q    <= 32'h0000_0000;
        end else begin
            in_s1      <= PortIn;
            in_s2      <= in_s1;
            in_prev    <= in_s2;
            change_irq <= changed;

            if (we && (off == OFF_PORT_OUT))
                port_out_q <= WriteData;

            // A fresh input change outranks a simultaneous clear so no event is lost.
            if (change_seen)
                changed <= 1'b1;
            else if (status_clear)
                changed <= 1'b0;

            if (we && (off == OFF_CYCLE))
                cycle_q <= WriteData;
            else
                cycle_q <= cycle_q + 32'd1;
        end
    end

    // NOTE: the default assignment ahead of the case keeps this block free of latches.
    always_comb begin
        rd_value = 32'h0000_0000;
        case (off)
            OFF_PORT_OUT: rd_value = port_out_q;
            OFF_PORT_IN:  rd_value = {24'h00_0000, in_s2};
            OFF_STATUS:   rd_value = {31'h0000_0000, changed};
            OFF_CYCLE:    rd_value = cycle_q;
            default:      rd_value = 32'h0000_0000;
        endcase
    end

    assign ReadData  = (MemRead && IOSelect) ? rd_value : 32'h0000_0000;
    assign PortOut   = port_out_q;
    assign ChangeIRQ = change_irq;

endmodule

// File: tb/tb_mmio_port_unit.sv
// Directed bench for mmio_port_unit: inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns after that, well away from the active edge.
module tb_mmio_port_unit;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        IOSelect;
    logic [31:0] PortOut;
    logic        ChangeIRQ;

    int vectors;
    int miscompares;

    mmio_port_unit #(
        .BASE_ADDR(BASE),
        .OUT_RESET(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .PortIn   (PortIn),
        .ReadData (ReadData),
        .IOSelect (IOSelect),
        .PortOut  (PortOut),
        .ChangeIRQ(ChangeIRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and leave 1 ns for outputs to settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic wr, input logic rd);
        Address   = addr;
        WriteData = wdata;
        MemWrite  = wr;
        MemRead   = rd;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        PortIn      = 8'h00;
        bus(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        check("reset_portout", PortOut, 32'h0);
        check("reset_irq", {31'h0, ChangeIRQ}, 32'h0);

        // Output port store and non-writing neighbours
        bus(BASE, 32'hA5A5_0F0F, 1'b1, 1'b0);
        check("iosel_base", {31'h0, IOSelect}, 32'h1);
        tick();
        bus(BASE + 32'h4, 32'h1234_5678, 1'b1, 1'b0);
        check("portout_store", PortOut, 32'hA5A5_0F0F);
        tick();
        bus(BASE + 32'h10, 32'h0000_0000, 1'b1, 1'b0);
        check("portout_after_portin_sw", PortOut, 32'hA5A5_0F0F);
        check("iosel_outside", {31'h0, IOSelect}, 32'h0);
        tick();
        bus(BASE, 32'h0, 1'b0, 1'b0);
        check("portout_after_outside_sw", PortOut, 32'hA5A5_0F0F);

        // Counter load, wrap, and same-cycle read of the old value
        bus(BASE + 32'hC, 32'd100, 1'b1, 1'b0);
        tick();
        bus(BASE + 32'hC, 32'hFFFF_FFFE, 1'b1, 1'b1);
        check("cycle_pre_store_read", ReadData, 32'd100);
        tick();
        bus(BASE + 32'hC, 32'h0, 1'b0, 1'b1);
        check("cycle_loaded", ReadData, 32'hFFFF_FFFE);
        tick();
        check("cycle_plus1", ReadData, 32'hFFFF_FFFF);
        tick();
        check("cycle_wrap", ReadData, 32'h0000_0000);

        // Input synchroniser latency and change flag
        bus(BASE + 32'h4, 32'h0, 1'b0, 1'b1);
        PortIn = 8'h3C;
        #1;
        check("portin_before_k", ReadData, 32'h0);
        tick();
        check("portin_after_k", ReadData, 32'h0);
        tick();
        check("portin_after_k1", ReadData, 32'h3C);
        bus(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
        check("status_after_k1", ReadData, 32'h0);
        tick();
        check("status_after_k2", ReadData, 32'h1);
        check("irq_after_k2", {31'h0, ChangeIRQ}, 32'h0);
        tick();
        check("irq_after_k3", {31'h0, ChangeIRQ}, 32'h1);

        // W1C racing a new change: set wins
        PortIn = 8'h3D;
        tick();
        tick();
        bus(BASE + 32'h8, 32'h1, 1'b1, 1'b0);
        tick();
        bus(BASE + 32'h8, 32'h1, 1'b1, 1'b1);
        check("status_w1c_race", ReadData, 32'h1);
        tick();
        bus(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
        check("status_w1c_clear", ReadData, 32'h0);
        tick();
        check("irq_cleared", {31'h0, ChangeIRQ}, 32'h0);

        // Read gating and ignored byte offset
        bus(BASE, 32'h0, 1'b0, 1'b0);
        check("rd_gated_data", ReadData, 32'h0);
        check("rd_gated_iosel", {31'h0, IOSelect}, 32'h1);
        bus(BASE + 32'h2, 32'h0, 1'b0, 1'b1);
        check("rd_unaligned", ReadData, 32'hA5A5_0F0F);
        bus(BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        check("rd_outside", ReadData, 32'h0);

        // Raise the interrupt, then reset mid-cycle with a store in flight
        PortIn = 8'h81;
        tick();
        tick();
        tick();
        tick();
        check("irq_before_reset", {31'h0, ChangeIRQ}, 32'h1);
        bus(BASE, 32'hDEAD_BEEF, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_portout", PortOut, 32'h0);
        check("midreset_irq", {31'h0, ChangeIRQ}, 32'h0);
        bus(BASE + 32'hC, 32'h0, 1'b0, 1'b1);
        check("midreset_cycle", ReadData, 32'h0);
        bus(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
        check("midreset_status", ReadData, 32'h0);
        bus(BASE, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        bus(BASE, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        check("store_lost_in_reset", PortOut, 32'h0);

        // PortIn held non-zero through reset registers as a change after release
        bus(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        check("status_after_release", ReadData, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
